sk6812_rx_decoder: RTL

//  Receive-side decoder for the single-wire SK6812RGBW NRZ LED protocol driven by wb_SK6812RGBW.

---
 rtl/sk6812_rx_decoder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sk6812_rx_decoder.sv
// SK6812RGBW NRZ receive decoder: pulse-width bit classifier, 32-bit GRBW word packer,
// reset-gap frame detection and a small word FIFO with a valid/ready output.
module sk6812_rx_decoder #(
    parameter int T_THRESH_CLKS = 23,
    parameter int MIN_HIGH_CLKS = 5,
    parameter int MAX_HIGH_CLKS = 50,
    parameter int RESET_CLKS    = 4000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_end,
    output logic [15:0] frame_words,
    output logic        err_glitch,
    output logic        err_long,
    output logic        err_partial,
    output logic        overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [15:0]      C_THRESH = 16'(T_THRESH_CLKS);
    localparam logic [15:0]      C_MIN    = 16'(MIN_HIGH_CLKS);
    localparam logic [15:0]      C_MAX    = 16'(MAX_HIGH_CLKS);
    localparam logic [15:0]      C_RESET  = 16'(RESET_CLKS);
    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_WAIT_GAP,
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_line;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, whatever the block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line = r_sync2;

    // ------------------------------------------------------------------
    // Decoder state
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_high_cnt;
    logic [15:0] r_low_cnt;
    logic [30:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_words;
    logic [15:0] r_frame_words;
    logic        r_frame_end;
    logic        r_err_glitch;
    logic        r_err_long;
    logic        r_err_partial;

    logic [15:0] w_high_inc;
    logic [15:0] w_low_inc;
    logic [15:0] w_words_inc;
    logic        w_bit;
    logic        w_push;
    logic [31:0] w_push_word;

    assign w_high_inc  = (r_high_cnt == 16'hFFFF) ? r_high_cnt : r_high_cnt + 16'd1;
    assign w_low_inc   = (r_low_cnt  == 16'hFFFF) ? r_low_cnt  : r_low_cnt  + 16'd1;
    assign w_words_inc = (r_words    == 16'hFFFF) ? r_words    : r_words    + 16'd1;
    assign w_bit       = (r_high_cnt >= C_THRESH);

    // The 32nd accepted bit completes a word in the falling-edge cycle itself.
    assign w_push      = (r_state == S_HIGH) && !w_line && (r_high_cnt >= C_MIN)
                         && (r_bit_cnt == 5'd31);
    assign w_push_word = {r_shift, w_bit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_WAIT_GAP;
            r_high_cnt    <= '0;
            r_low_cnt     <= '0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_words       <= '0;
            r_frame_words <= '0;
            r_frame_end   <= 1'b0;
            r_err_glitch  <= 1'b0;
            r_err_long    <= 1'b0;
            r_err_partial <= 1'b0;
        end else begin
            r_frame_end   <= 1'b0;
            r_err_glitch  <= 1'b0;
            r_err_long    <= 1'b0;
            r_err_partial <= 1'b0;

            case (r_state)
                S_WAIT_GAP: begin
                    if (w_line) begin
                        r_low_cnt <= '0;
                    end else begin
                        r_low_cnt <= w_low_inc;
                        if (w_low_inc >= C_RESET) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_IDLE: begin
                    if (w_line) begin
                        r_state    <= S_HIGH;
                        r_high_cnt <= 16'd1;
                    end
                end

                S_HIGH: begin
                    if (w_line) begin
                        if (w_high_inc > C_MAX) begin
                            r_err_long <= 1'b1;
                            r_state    <= S_WAIT_GAP;
                            r_low_cnt  <= '0;
                            r_bit_cnt  <= '0;
                            r_words    <= '0;
                        end else begin
                            r_high_cnt <= w_high_inc;
                        end
                    end else if (r_high_cnt < C_MIN) begin
                        r_err_glitch <= 1'b1;
                        r_state      <= S_WAIT_GAP;
                        r_low_cnt    <= '0;
                        r_bit_cnt    <= '0;
                        r_words      <= '0;
                    end else begin
                        r_shift   <= {r_shift[29:0], w_bit};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd31) begin
                            r_words <= w_words_inc;
                        end
                        r_state   <= S_LOW;
                        r_low_cnt <= 16'd1;
                    end
                end

                S_LOW: begin
                    if (w_line) begin
                        r_state    <= S_HIGH;
                        r_high_cnt <= 16'd1;
                    end else begin
                        r_low_cnt <= w_low_inc;
                        if (w_low_inc >= C_RESET) begin
                            if (r_bit_cnt != 5'd0) begin
                                r_err_partial <= 1'b1;
                            end else if (r_words != 16'd0) begin
                                r_frame_end   <= 1'b1;
                                r_frame_words <= r_words;
                            end
                            r_words   <= '0;
                            r_bit_cnt <= '0;
                            r_state   <= S_IDLE;
                        end
                    end
                end

                default: r_state <= S_WAIT_GAP;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO with registered head
    // ------------------------------------------------------------------
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_word_data;
    logic             r_word_valid;
    logic             r_overrun;

    logic             w_pop;
    logic             w_push_ok;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_count_next;
    logic [31:0]      w_head_next;

    assign w_pop        = r_word_valid && word_ready;
    assign w_push_ok    = w_push && ((r_count < C_DEPTH) || w_pop);
    assign w_rd_next    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    assign w_count_next = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);

    // A word written this cycle is not in the array yet; forward it when it becomes the head.
    assign w_head_next  = (w_push_ok && (w_rd_next == r_wr_ptr)) ? w_push_word
                                                                 : r_mem[w_rd_next];

    // NOTE: the storage array has no reset; only pointers, count and the
    // output registers do, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr     <= w_rd_next;
            r_count      <= w_count_next;
            r_word_valid <= (w_count_next != '0);
            r_word_data  <= (w_count_next != '0) ? w_head_next : 32'd0;
            r_overrun    <= w_push && !w_push_ok;
        end
    end

    assign word_data   = r_word_data;
    assign word_valid  = r_word_valid;
    assign frame_end   = r_frame_end;
    assign frame_words = r_frame_words;
    assign err_glitch  = r_err_glitch;
    assign err_long    = r_err_long;
    assign err_partial = r_err_partial;
    assign overrun     = r_overrun;

endmodule
